// File: rtl/serial_receiver_pkg.sv
// ============================================================================
// Module      : serial_receiver_pkg
// Description : Shared transceiver defaults and serial FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_receiver_pkg;

    localparam int c_CLKS_PER_BIT = 10;
    localparam int c_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/bit_sync.sv
// ============================================================================
// Module      : bit_sync
// Description : Two-flop synchronizer for an asynchronous level, resets high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], d};
        end
    end

    assign q = r_sync[1];

endmodule

`default_nettype wire

// File: rtl/serial_receiver.sv
// ============================================================================
// Module      : serial_receiver
// Description : Start/data/stop serial frame receiver sampling at mid-bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT,
    parameter int DATA_BITS    = c_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    ser_state_t           r_state,  w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [c_IDX_W-1:0]   r_idx,    w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift,  w_shift_nxt;
    logic [DATA_BITS-1:0] r_data,   w_data_nxt;
    logic                 r_valid,  w_valid_nxt;
    logic                 r_ferr,   w_ferr_nxt;
    logic                 r_brk,    w_brk_nxt;

    bit_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_brk   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_brk   <= w_brk_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_brk_nxt   = r_brk;
        case (r_state)
            ST_IDLE: begin
                // After a framing error the line must be seen high before a new start is accepted
                if (w_rx_s) begin
                    w_brk_nxt = 1'b0;
                end else if (!r_brk) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                end
            end
            ST_START: begin
                if (r_cnt == c_CNT_HALF) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = w_rx_s;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop leaves half a bit of margin for a back-to-back start
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    if (w_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                        w_brk_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_receiver.sv
// ============================================================================
// Module      : tb_serial_receiver
// Description : Self-checking bench for serial_receiver with frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_receiver;

    localparam int c_CPB = 10;
    localparam int c_DB  = 8;
    // Cycle count from driving the start bit to seeing a pulse at the following negedge
    localparam int c_LAT = 2 + c_CPB / 2 + c_CPB * (c_DB + 1) + 1;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic [7:0] exp_data;
        logic       exp_v;
        logic       exp_f;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   n_valid = 0;
    int   n_ferr = 0;
    int   valid_cyc = -1;
    int   ferr_cyc = -1;
    logic both_seen = 1'b0;

    vec_t       vecs [5];
    logic [7:0] exp_last;

    serial_receiver #(
        .CLKS_PER_BIT (c_CPB),
        .DATA_BITS    (c_DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            n_valid++;
            valid_cyc = cyc;
        end
        if (frame_err) begin
            n_ferr++;
            ferr_cyc = cyc;
        end
        if (data_valid && frame_err) both_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(posedge clk);
        #2 rx_in = b;
        repeat (c_CPB - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(posedge clk);
        #2 rx_in = 1'b0;
        start_cyc = cyc;
        repeat (c_CPB - 1) @(posedge clk);
        for (int i = 0; i < c_DB; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input logic stop,
                             input int gap, input logic [7:0] exp_d,
                             input logic exp_v, input logic exp_f);
        int v0;
        int f0;
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(d, stop);
        @(negedge clk);
        check({name, "_valid_cnt"}, n_valid - v0, {31'd0, exp_v});
        check({name, "_ferr_cnt"}, n_ferr - f0, {31'd0, exp_f});
        check({name, "_data"}, data_out, exp_d);
        if (exp_v) check({name, "_valid_lat"}, valid_cyc - start_cyc, c_LAT);
        if (exp_f) check({name, "_ferr_lat"}, ferr_cyc - start_cyc, c_LAT);
        if (!stop || gap > 0) begin
            @(posedge clk);
            #2 rx_in = 1'b1;
            repeat (gap) @(posedge clk);
        end
    endtask

    initial begin
        int v0;
        int f0;
        logic [7:0] d;
        logic       s;
        int         g;

        vecs[0] = '{8'hA5, 1'b1, 5,  8'hA5, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 10, 8'hA5, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 0,  8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 0,  8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h81, 1'b1, 5,  8'h81, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data_out, 8'h00);
        check("rst_valid", data_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (5) @(posedge clk);

        for (int i = 0; i < 5; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop, vecs[i].gap,
                      vecs[i].exp_data, vecs[i].exp_v, vecs[i].exp_f);
        end
        exp_last = 8'h81;

        // False start: three low cycles only
        v0 = n_valid;
        f0 = n_ferr;
        @(posedge clk);
        #2 rx_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("false_busy_mid", busy, 1'b1);
        #1 rx_in = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("false_busy_end", busy, 1'b0);
        check("false_valid", n_valid - v0, 0);
        check("false_ferr", n_ferr - f0, 0);
        check("false_data", data_out, exp_last);

        // Break: line low for 200 cycles
        v0 = n_valid;
        f0 = n_ferr;
        @(posedge clk);
        #2 rx_in = 1'b0;
        start_cyc = cyc;
        repeat (150) @(posedge clk);
        #1 check("brk_busy_150", busy, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        check("brk_ferr_cnt", n_ferr - f0, 1);
        check("brk_ferr_lat", ferr_cyc - start_cyc, c_LAT);
        check("brk_valid_cnt", n_valid - v0, 0);
        #1 rx_in = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("brk_idle_busy", busy, 1'b0);
        check("brk_idle_ferr", n_ferr - f0, 1);
        check("brk_data", data_out, exp_last);
        run_frame("after_brk", 8'h5A, 1'b1, 5, 8'h5A, 1'b1, 1'b0);

        // Reset during data bit 4
        v0 = n_valid;
        f0 = n_ferr;
        d = 8'h55;
        @(posedge clk);
        #2 rx_in = 1'b0;
        repeat (c_CPB - 1) @(posedge clk);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        @(posedge clk);
        #2 rx_in = d[4];
        repeat (4) @(posedge clk);
        #1 check("abort_busy_pre", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_data", data_out, 8'h00);
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (120) @(posedge clk);
        #1;
        check("abort_valid", n_valid - v0, 0);
        check("abort_ferr", n_ferr - f0, 0);
        run_frame("post_abort", 8'h01, 1'b1, 5, 8'h01, 1'b1, 1'b0);
        exp_last = 8'h01;

        // Randomized frames against the frame-level model
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            g = s ? int'($urandom_range(0, 8)) : int'($urandom_range(3, 8));
            if (s) exp_last = d;
            run_frame($sformatf("rnd%0d", i), d, s, g, exp_last, s, !s);
        end

        check("no_overlap", {31'd0, both_seen}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
